cga_bus_bridge: RTL and testbench
=================================

Name: cga_bus_bridge

Overview:
- Upstream neighbour of the CGA adapter.
- Converts the CPU core's level request/acknowledge handshake into ISA-style strobes: bus_a, bus_aen, bus_memr_l, bus_memw_l, bus_ior_l, bus_iow_l and bus_d.
- Samples the adapter's read data and honours the adapter's ready/wait-state line.
- Enforces programmable setup, minimum strobe width and hold, with a ready timeout so a hung device cannot stall the CPU.

Parameters:
SETUP_CYCLES, 2, cycles address/data are driven before strobe assertion (1..15)
STROBE_MIN, 4, minimum cycles a strobe is held low (1..15)
HOLD_CYCLES, 1, cycles address/data held after strobe release (0..15)
READY_TIMEOUT, 255, cycles bus_rdy may stay low after STROBE_MIN before abort (1..255)
TIMEOUT_DATA, 8'hFF, read data returned on timeout

Ports:
clk  in  1  system clock (28.636MHz domain)
reset_l  in  1  synchronous reset, active low
cpu_req  in  1  transaction request, level, held until cpu_ack
cpu_wr  in  1  1=write, 0=read
cpu_io  in  1  1=I/O space, 0=memory space
cpu_addr  in  20  transaction address
cpu_dout  in  8  write data
cpu_din  out  8  read data, valid with cpu_ack
cpu_ack  out  1  one-cycle completion pulse
cpu_timeout  out  1  qualifies cpu_ack: transaction aborted
cpu_busy  out  1  high whenever state != IDLE
bus_a  out  20  ISA address
bus_d  out  8  ISA write data
bus_d_oe  out  1  high while a write transaction drives bus_d
bus_in  in  8  ISA read data from adapter
bus_aen  out  1  address enable, low only during a transaction
bus_memr_l, bus_memw_l, bus_ior_l, bus_iow_l  out  1 each  ISA strobes, active low
bus_rdy  in  1  ISA channel ready; tie high if unused

Behaviour:
- Reset (reset_l low at a clk edge):
  - state=IDLE; all strobes=1; bus_aen=1; bus_d_oe=0.
  - cpu_ack=0, cpu_timeout=0, cpu_din=8'h00, bus_a=0, bus_d=0.
  - Any transaction in flight is dropped with no ack.
  - Asserting reset mid-strobe releases the strobe at the same edge.
- States: IDLE, SETUP, STROBE, HOLD, DONE.
- IDLE:
  - On an edge with cpu_req=1 and cpu_ack=0, latch addr, wr, io and dout.
  - Drive bus_a; bus_aen=0; bus_d_oe=cpu_wr; load counter=SETUP_CYCLES; go to SETUP.
  - bus_a and bus_d hold their last values while idle.
- SETUP:
  - Decrement the counter; at 1 → STROBE.
  - Assert exactly one strobe, selected by {io,wr}: memr, memw, ior or iow.
  - Load counter=STROBE_MIN.
- STROBE:
  - Count down to STROBE_MIN complete, then sample bus_rdy each edge.
  - First edge with bus_rdy=1 after the minimum: release the strobe; on reads, capture bus_in into cpu_din at that edge.
  - Go to HOLD, or to DONE if HOLD_CYCLES=0.
  - Low time is therefore STROBE_MIN + (cycles bus_rdy was low after the minimum).
- Timeout:
  - If bus_rdy stays low for READY_TIMEOUT cycles after the minimum, release the strobe and set the sticky timeout flag.
  - Reads return cpu_din=TIMEOUT_DATA.
- HOLD: bus_a, bus_aen=0 and bus_d/bus_d_oe are held for HOLD_CYCLES, then → DONE.
- DONE:
  - cpu_ack=1 and cpu_timeout=flag for exactly one cycle.
  - bus_aen=1, bus_d_oe=0, clear flag → IDLE.
  - cpu_din holds until the next read completes.
- Handshake:
  - cpu_req is sampled only in IDLE with cpu_ack low.
  - A continuously held req starts the next transaction one edge after the ack cycle.
  - Request inputs may change freely outside IDLE; they are not resampled.
- Latency (defaults, bus_rdy=1, req sampled at edge E0):
  - Strobe low from edge E0+2 to E0+6.
  - Read data captured at E0+6; cpu_ack high in cycle after E0+7.
- Exactly one strobe is low at any time.
- No strobe is low while bus_aen=1.
- bus_rdy changes during SETUP or HOLD are ignored.

Test Plan:
- Memory read 0xB8002, bus_in=8'h5A, bus_rdy=1 → bus_memr_l low exactly 4 cycles from E0+2; cpu_din=8'h5A with cpu_ack, cpu_timeout=0; bus_aen low E0+1..E0+7.
- I/O write 0x3D8 data 8'h29 → bus_iow_l low 4 cycles; bus_d=8'h29 and bus_d_oe=1 from E0+1 through hold; other strobes stay 1.
- Memory write with bus_rdy held low 5 cycles past the minimum → bus_memw_l low 9 cycles; ack follows 1 hold cycle later.
- bus_rdy stuck low on a read → strobe released after 4+255 cycles; cpu_ack=1, cpu_timeout=1, cpu_din=8'hFF; next transaction has cpu_timeout=0.
- cpu_req held high for two reads → second bus_aen falling edge exactly one cycle after the first ack cycle; no overlap of strobes.
- reset_l pulsed low mid-STROBE → strobe=1, bus_aen=1 at that edge; no cpu_ack; the next request completes normally.

Source files
------------

// File: rtl/cga_bus_bridge.sv
// CPU-to-ISA bus bridge for the CGA adapter: turns a level req/ack handshake into
// timed ISA strobes with programmable setup, strobe width, hold and ready timeout.
module cga_bus_bridge #(
  parameter int         SETUP_CYCLES  = 2,
  parameter int         STROBE_MIN    = 4,
  parameter int         HOLD_CYCLES   = 1,
  parameter int         READY_TIMEOUT = 255,
  parameter logic [7:0] TIMEOUT_DATA  = 8'hFF
) (
  input  logic        clk,
  input  logic        reset_l,
  input  logic        cpu_req,
  input  logic        cpu_wr,
  input  logic        cpu_io,
  input  logic [19:0] cpu_addr,
  input  logic [7:0]  cpu_dout,
  output logic [7:0]  cpu_din,
  output logic        cpu_ack,
  output logic        cpu_timeout,
  output logic        cpu_busy,
  output logic [19:0] bus_a,
  output logic [7:0]  bus_d,
  output logic        bus_d_oe,
  input  logic [7:0]  bus_in,
  output logic        bus_aen,
  output logic        bus_memr_l,
  output logic        bus_memw_l,
  output logic        bus_ior_l,
  output logic        bus_iow_l,
  input  logic        bus_rdy
);

  typedef enum logic [2:0] {IDLE, SETUP, STROBE, HOLD, DONE} state_t;

  localparam logic [3:0] SETUP_LD  = 4'(SETUP_CYCLES);
  localparam logic [3:0] STROBE_LD = 4'(STROBE_MIN);
  localparam logic [3:0] HOLD_LD   = 4'(HOLD_CYCLES);
  localparam logic [7:0] TMO       = 8'(READY_TIMEOUT);

  state_t      state, state_nxt;
  logic [3:0]  cnt, cnt_nxt;
  logic [7:0]  tcnt, tcnt_nxt;
  logic        flag, flag_nxt;
  logic        wr_q, wr_nxt;
  logic        io_q, io_nxt;
  logic [19:0] a_nxt;
  logic [7:0]  d_nxt;
  logic [7:0]  din_nxt;
  logic        aen_nxt;
  logic        doe_nxt;
  // One-hot strobe vector, bit index = {io, wr}: memr, memw, ior, iow.
  logic [3:0]  strb, strb_nxt;

  // NOTE: every *_nxt gets a default first so no path through the case infers a latch.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    tcnt_nxt  = tcnt;
    flag_nxt  = flag;
    wr_nxt    = wr_q;
    io_nxt    = io_q;
    a_nxt     = bus_a;
    d_nxt     = bus_d;
    din_nxt   = cpu_din;
    aen_nxt   = bus_aen;
    doe_nxt   = bus_d_oe;
    strb_nxt  = strb;

    unique case (state)
      IDLE: begin
        if (cpu_req) begin
          wr_nxt    = cpu_wr;
          io_nxt    = cpu_io;
          a_nxt     = cpu_addr;
          d_nxt     = cpu_dout;
          aen_nxt   = 1'b0;
          doe_nxt   = cpu_wr;
          cnt_nxt   = SETUP_LD;
          state_nxt = SETUP;
        end
      end
      SETUP: begin
        if (cnt <= 4'd1) begin
          strb_nxt  = 4'b0001 << {io_q, wr_q};
          cnt_nxt   = STROBE_LD;
          tcnt_nxt  = 8'd0;
          state_nxt = STROBE;
        end else begin
          cnt_nxt = cnt - 4'd1;
        end
      end
      STROBE: begin
        if (cnt > 4'd1) begin
          cnt_nxt = cnt - 4'd1;
        end else if (bus_rdy || tcnt == TMO) begin
          // Minimum width met: release on ready, or abort once the timeout expires.
          strb_nxt = 4'b0000;
          if (!bus_rdy) flag_nxt = 1'b1;
          if (!wr_q) din_nxt = bus_rdy ? bus_in : TIMEOUT_DATA;
          if (HOLD_CYCLES == 0) begin
            aen_nxt   = 1'b1;
            doe_nxt   = 1'b0;
            state_nxt = DONE;
          end else begin
            cnt_nxt   = HOLD_LD;
            state_nxt = HOLD;
          end
        end else begin
          tcnt_nxt = tcnt + 8'd1;
        end
      end
      HOLD: begin
        if (cnt <= 4'd1) begin
          aen_nxt   = 1'b1;
          doe_nxt   = 1'b0;
          state_nxt = DONE;
        end else begin
          cnt_nxt = cnt - 4'd1;
        end
      end
      DONE: begin
        flag_nxt  = 1'b0;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk) begin
    if (!reset_l) begin
      state    <= IDLE;
      cnt      <= 4'd0;
      tcnt     <= 8'd0;
      flag     <= 1'b0;
      wr_q     <= 1'b0;
      io_q     <= 1'b0;
      bus_a    <= 20'h0;
      bus_d    <= 8'h00;
      cpu_din  <= 8'h00;
      bus_aen  <= 1'b1;
      bus_d_oe <= 1'b0;
      strb     <= 4'b0000;
    end else begin
      state    <= state_nxt;
      cnt      <= cnt_nxt;
      tcnt     <= tcnt_nxt;
      flag     <= flag_nxt;
      wr_q     <= wr_nxt;
      io_q     <= io_nxt;
      bus_a    <= a_nxt;
      bus_d    <= d_nxt;
      cpu_din  <= din_nxt;
      bus_aen  <= aen_nxt;
      bus_d_oe <= doe_nxt;
      strb     <= strb_nxt;
    end
  end

  assign cpu_ack     = (state == DONE);
  assign cpu_timeout = (state == DONE) && flag;
  assign cpu_busy    = (state != IDLE);
  assign bus_memr_l  = ~strb[0];
  assign bus_memw_l  = ~strb[1];
  assign bus_ior_l   = ~strb[2];
  assign bus_iow_l   = ~strb[3];

endmodule

// File: tb/tb_cga_bus_bridge.sv
// Directed bench for cga_bus_bridge: vector table of single transactions plus
// hand-written back-to-back and mid-strobe reset sequences.
module tb_cga_bus_bridge;

  localparam int SETUP = 2;
  localparam int SMIN  = 4;
  localparam int HOLD  = 1;
  localparam int TMO   = 255;

  logic        clk = 1'b0;
  logic        reset_l;
  logic        cpu_req, cpu_wr, cpu_io;
  logic [19:0] cpu_addr;
  logic [7:0]  cpu_dout;
  logic [7:0]  cpu_din;
  logic        cpu_ack, cpu_timeout, cpu_busy;
  logic [19:0] bus_a;
  logic [7:0]  bus_d;
  logic        bus_d_oe;
  logic [7:0]  bus_in;
  logic        bus_aen, bus_memr_l, bus_memw_l, bus_ior_l, bus_iow_l;
  logic        bus_rdy;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  cga_bus_bridge #(
    .SETUP_CYCLES(SETUP), .STROBE_MIN(SMIN), .HOLD_CYCLES(HOLD),
    .READY_TIMEOUT(TMO), .TIMEOUT_DATA(8'hFF)
  ) dut (
    .clk(clk), .reset_l(reset_l),
    .cpu_req(cpu_req), .cpu_wr(cpu_wr), .cpu_io(cpu_io),
    .cpu_addr(cpu_addr), .cpu_dout(cpu_dout), .cpu_din(cpu_din),
    .cpu_ack(cpu_ack), .cpu_timeout(cpu_timeout), .cpu_busy(cpu_busy),
    .bus_a(bus_a), .bus_d(bus_d), .bus_d_oe(bus_d_oe), .bus_in(bus_in),
    .bus_aen(bus_aen), .bus_memr_l(bus_memr_l), .bus_memw_l(bus_memw_l),
    .bus_ior_l(bus_ior_l), .bus_iow_l(bus_iow_l), .bus_rdy(bus_rdy)
  );

  typedef struct {
    string       name;
    logic        io;
    logic        wr;
    logic [19:0] addr;
    logic [7:0]  dout;
    logic [7:0]  bin;
    int          rdy_low;   // cycles bus_rdy is held low after the minimum width
    bit          noise;     // pull bus_rdy low during setup/hold/early strobe
    int          exp_low;
    logic [7:0]  exp_din;
    bit          exp_to;
  } vec_t;

  vec_t vecs[6];

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [3:0] strobes();
    return ~{bus_iow_l, bus_ior_l, bus_memw_l, bus_memr_l};
  endfunction

  task automatic run_vec(input vec_t v);
    int n = 0, low = 0, aen_lo = 0, first_low = 0, ack_at = 0;
    int viol = 0, a_err = 0, d_err = 0;
    logic [3:0] s, seen = 4'b0000;
    logic [7:0] din_at = 8'h00;
    logic       to_at = 1'b0;
    bit         done = 0;
    @(negedge clk);
    cpu_io = v.io; cpu_wr = v.wr; cpu_addr = v.addr; cpu_dout = v.dout;
    bus_in = ~v.bin; bus_rdy = !v.noise; cpu_req = 1'b1;
    while (!done && n < 600) begin
      @(negedge clk);
      n++;
      s = strobes();
      if (s != 4'b0000) begin
        low++;
        seen |= s;
        if (first_low == 0) first_low = n;
      end
      if ($countones(s) > 1 || (s != 4'b0000 && bus_aen)) viol++;
      if (!bus_aen) begin
        aen_lo++;
        if (bus_a !== v.addr) a_err++;
        if (bus_d_oe !== v.wr || (v.wr && bus_d !== v.dout)) d_err++;
        cpu_addr = ~v.addr; cpu_dout = ~v.dout; cpu_wr = ~v.wr; cpu_io = ~v.io;
      end
      if (cpu_ack) begin
        ack_at = n; din_at = cpu_din; to_at = cpu_timeout; done = 1; cpu_req = 1'b0;
      end
      bus_in = (s != 4'b0000) ? v.bin : ~v.bin;
      if (s != 4'b0000 && low >= SMIN) bus_rdy = (low >= SMIN + v.rdy_low);
      else bus_rdy = !v.noise;
    end
    bus_rdy = 1'b1;
    check({v.name, "_ack_seen"}, int'(done), 1);
    check({v.name, "_strobe_low"}, low, v.exp_low);
    check({v.name, "_strobe_sel"}, int'(seen), int'(4'b0001 << {v.io, v.wr}));
    check({v.name, "_strobe_start"}, first_low, SETUP + 1);
    check({v.name, "_aen_low"}, aen_lo, SETUP + v.exp_low + HOLD);
    check({v.name, "_ack_at"}, ack_at, SETUP + v.exp_low + HOLD + 1);
    check({v.name, "_din"}, int'(din_at), int'(v.exp_din));
    check({v.name, "_timeout"}, int'(to_at), int'(v.exp_to));
    check({v.name, "_strobe_rules"}, viol, 0);
    check({v.name, "_addr_hold"}, a_err, 0);
    check({v.name, "_data_hold"}, d_err, 0);
  endtask

  initial begin
    vecs[0] = '{"mem_rd",      1'b0, 1'b0, 20'hB8002, 8'h00, 8'h5A, 0,    0, 4,   8'h5A, 0};
    vecs[1] = '{"io_wr",       1'b1, 1'b1, 20'h003D8, 8'h29, 8'hE1, 0,    0, 4,   8'h5A, 0};
    vecs[2] = '{"mem_wr_wait", 1'b0, 1'b1, 20'hB8123, 8'hC3, 8'h00, 5,    0, 9,   8'h5A, 0};
    vecs[3] = '{"io_rd_noise", 1'b1, 1'b0, 20'h003DA, 8'h00, 8'h09, 0,    1, 4,   8'h09, 0};
    vecs[4] = '{"rd_stuck",    1'b0, 1'b0, 20'hB8004, 8'h00, 8'h77, 1000, 0, 259, 8'hFF, 1};
    vecs[5] = '{"io_rd_after", 1'b1, 1'b0, 20'h003D9, 8'h00, 8'h3C, 2,    0, 6,   8'h3C, 0};

    reset_l = 1'b0; cpu_req = 1'b0; cpu_wr = 1'b0; cpu_io = 1'b0;
    cpu_addr = 20'h0; cpu_dout = 8'h00; bus_in = 8'h00; bus_rdy = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_ack", int'(cpu_ack), 0);
    check("rst_timeout", int'(cpu_timeout), 0);
    check("rst_din", int'(cpu_din), 0);
    check("rst_bus_a", int'(bus_a), 0);
    check("rst_bus_d", int'(bus_d), 0);
    check("rst_aen", int'(bus_aen), 1);
    check("rst_d_oe", int'(bus_d_oe), 0);
    check("rst_strobes", int'(strobes()), 0);
    check("rst_busy", int'(cpu_busy), 0);
    reset_l = 1'b1;

    foreach (vecs[i]) run_vec(vecs[i]);

    // Back-to-back reads with cpu_req held high.
    begin
      int n = 0, acks = 0, ack1 = 0, falls = 0, fall2 = 0, viol = 0;
      logic prev_aen = 1'b1;
      logic [7:0] din2 = 8'h00;
      @(negedge clk);
      cpu_io = 1'b0; cpu_wr = 1'b0; cpu_addr = 20'hB8010; bus_in = 8'h11;
      bus_rdy = 1'b1; cpu_req = 1'b1;
      while (acks < 2 && n < 100) begin
        @(negedge clk);
        n++;
        if ($countones(strobes()) > 1 || (strobes() != 4'b0000 && bus_aen)) viol++;
        if (prev_aen && !bus_aen) begin
          falls++;
          if (falls == 2) fall2 = n;
        end
        prev_aen = bus_aen;
        if (cpu_ack) begin
          acks++;
          if (acks == 1) ack1 = n;
          else din2 = cpu_din;
        end
      end
      cpu_req = 1'b0;
      check("b2b_acks", acks, 2);
      check("b2b_gap", fall2 - ack1, 2);
      check("b2b_din", int'(din2), 8'h11);
      check("b2b_rules", viol, 0);
    end

    // Reset pulsed in the middle of a write strobe.
    begin
      int n = 0, low = 0, acks = 0;
      @(negedge clk);
      cpu_io = 1'b0; cpu_wr = 1'b1; cpu_addr = 20'hB8200; cpu_dout = 8'h66;
      bus_rdy = 1'b1; cpu_req = 1'b1;
      while (low < 2 && n < 50) begin
        @(negedge clk);
        n++;
        if (strobes() != 4'b0000) low++;
      end
      check("mid_rst_reached", low, 2);
      reset_l = 1'b0; cpu_req = 1'b0;
      @(negedge clk);
      check("mid_rst_strobes", int'(strobes()), 0);
      check("mid_rst_aen", int'(bus_aen), 1);
      check("mid_rst_d_oe", int'(bus_d_oe), 0);
      check("mid_rst_busy", int'(cpu_busy), 0);
      check("mid_rst_din", int'(cpu_din), 0);
      reset_l = 1'b1;
      repeat (20) begin
        @(negedge clk);
        if (cpu_ack) acks++;
      end
      check("mid_rst_no_ack", acks, 0);
    end

    run_vec('{"post_rst_rd", 1'b0, 1'b0, 20'hB8FFF, 8'h00, 8'hAA, 0, 0, 4, 8'hAA, 0});

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
